// File: rtl/noc_packet_injector_pkg.sv
// Package: noc_packet_injector_pkg
// Purpose: Shared definitions for the local-port packet injector. It holds the
//   packet type field that the router arbiter decodes, the descriptor length
//   width, the injector FSM states, and helper functions that give the bit
//   offsets of the routing-header fields for a given mesh coordinate width.
// Ports: none (package).
package noc_packet_injector_pkg;

  localparam int PACKET_TYPE_WIDTH = 2;
  localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 2'b10;
  localparam int LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } inj_state_e;

  // Header fields are packed upward from bit 0 in this order: target y,
  // target x, source y, source x, then the payload length.
  function automatic int tgt_x_lsb(input int yw);
    return yw;
  endfunction

  function automatic int src_y_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int src_x_lsb(input int xw, input int yw);
    return xw + 2 * yw;
  endfunction

  function automatic int len_lsb(input int xw, input int yw);
    return 2 * (xw + yw);
  endfunction

endpackage

// File: rtl/noc_packet_injector_rr_pick.sv
// Module: noc_packet_injector_rr_pick
// Purpose: Combinational round-robin selector. Starting one position after the
//   last grant and wrapping around, returns the first active request.
// Ports:
//   req_i     in  N  request vector
//   last_i    in  W  index of the previous grant
//   any_o     out 1  at least one request is active
//   winner_o  out W  index of the selected request (0 when any_o is low)
module noc_packet_injector_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         any_o,
  output logic [W-1:0] winner_o
);

  logic [W-1:0] idx;

  // The previous grant itself is tried last, so a lone requester can still
  // win repeatedly.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Module: noc_packet_injector
// Purpose: Local-port packet source for a mesh router. Several requesters share
//   one router input; each packet is granted round-robin, sends one routing
//   header flit built from its descriptor, then passes its payload flits.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   src_x_i, src_y_i             own router coordinates (static)
//   req_valid_i / req_ready_o    descriptor handshake per requester
//   req_x_i, req_y_i, req_len_i  packed descriptor fields per requester
//   data_in_t{valid,ready,data}  packed payload streams per requester
//   out_t{valid,ready,data}      stream to the router local input
//   current_grant_o              requester owning the output
//   busy_o                       packet in progress (header or payload)
//   err_zero_len_o               one-cycle pulse after a len==0 descriptor
module noc_packet_injector
  import noc_packet_injector_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REQ_NUMBER       = 4,
  parameter int REQ_NUMBER_WIDTH = $clog2(REQ_NUMBER),
  parameter int MAX_ROUTERS_X    = 4,
  parameter int MAX_ROUTERS_Y    = 4,
  parameter int XW               = $clog2(MAX_ROUTERS_X),
  parameter int YW               = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [XW-1:0]                    src_x_i,
  input  logic [YW-1:0]                    src_y_i,
  input  logic [REQ_NUMBER-1:0]            req_valid_i,
  output logic [REQ_NUMBER-1:0]            req_ready_o,
  input  logic [REQ_NUMBER*XW-1:0]         req_x_i,
  input  logic [REQ_NUMBER*YW-1:0]         req_y_i,
  input  logic [REQ_NUMBER*LEN_WIDTH-1:0]  req_len_i,
  input  logic [REQ_NUMBER-1:0]            data_in_tvalid_i,
  output logic [REQ_NUMBER-1:0]            data_in_tready_o,
  input  logic [REQ_NUMBER*DATA_WIDTH-1:0] data_in_tdata_i,
  output logic                             out_tvalid_o,
  input  logic                             out_tready_i,
  output logic [DATA_WIDTH-1:0]            out_tdata_o,
  output logic [REQ_NUMBER_WIDTH-1:0]      current_grant_o,
  output logic                             busy_o,
  output logic                             err_zero_len_o
);

  localparam int TGT_X_LSB = tgt_x_lsb(YW);
  localparam int SRC_Y_LSB = src_y_lsb(XW, YW);
  localparam int SRC_X_LSB = src_x_lsb(XW, YW);
  localparam int LEN_LSB   = len_lsb(XW, YW);

  inj_state_e                  state_q, state_d;
  logic [REQ_NUMBER_WIDTH-1:0] grant_q, grant_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [DATA_WIDTH-1:0]       hdr_q, hdr_d;
  logic                        err_q, err_d;

  logic [XW-1:0]         req_x_a    [REQ_NUMBER];
  logic [YW-1:0]         req_y_a    [REQ_NUMBER];
  logic [LEN_WIDTH-1:0]  req_len_a  [REQ_NUMBER];
  logic [DATA_WIDTH-1:0] data_in_a  [REQ_NUMBER];

  logic                        pick_any;
  logic [REQ_NUMBER_WIDTH-1:0] pick_win;
  logic                        arb_en;
  logic [DATA_WIDTH-1:0]       hdr_new;

  for (genvar g = 0; g < REQ_NUMBER; g++) begin : g_unpack
    assign req_x_a[g]   = req_x_i[g*XW +: XW];
    assign req_y_a[g]   = req_y_i[g*YW +: YW];
    assign req_len_a[g] = req_len_i[g*LEN_WIDTH +: LEN_WIDTH];
    assign data_in_a[g] = data_in_tdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  noc_packet_injector_rr_pick #(
    .N (REQ_NUMBER),
    .W (REQ_NUMBER_WIDTH)
  ) u_rr_pick (
    .req_i    (req_valid_i),
    .last_i   (grant_q),
    .any_o    (pick_any),
    .winner_o (pick_win)
  );

  // Routing header for the current arbitration winner; captured on acceptance.
  always_comb begin
    hdr_new = '0;
    hdr_new[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] = ROUTING_HEADER;
    hdr_new[LEN_LSB +: LEN_WIDTH]  = req_len_a[pick_win];
    hdr_new[SRC_X_LSB +: XW]       = src_x_i;
    hdr_new[SRC_Y_LSB +: YW]       = src_y_i;
    hdr_new[TGT_X_LSB +: XW]       = req_x_a[pick_win];
    hdr_new[0 +: YW]               = req_y_a[pick_win];
  end

  // Arbitration is open in IDLE and on the last payload handshake, which is
  // what lets a new header follow the previous packet without a bubble.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    hdr_d            = hdr_q;
    err_d            = 1'b0;
    arb_en           = 1'b0;
    req_ready_o      = '0;
    data_in_tready_o = '0;
    out_tvalid_o     = 1'b0;
    out_tdata_o      = '0;

    case (state_q)
      ST_IDLE: arb_en = 1'b1;
      ST_HEADER: begin
        out_tvalid_o = 1'b1;
        out_tdata_o  = hdr_q;
        if (out_tready_i) begin
          cnt_d   = len_q;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        out_tvalid_o              = data_in_tvalid_i[grant_q];
        out_tdata_o               = data_in_a[grant_q];
        data_in_tready_o[grant_q] = out_tready_i;
        if (out_tready_i && data_in_tvalid_i[grant_q]) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
            arb_en  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero-length descriptor is consumed and flagged but starts no packet;
    // the pointer still moves so the next requester gets its turn.
    if (arb_en && pick_any) begin
      req_ready_o[pick_win] = 1'b1;
      grant_d               = pick_win;
      len_d                 = req_len_a[pick_win];
      hdr_d                 = hdr_new;
      if (req_len_a[pick_win] == '0) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_HEADER;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
    end
  end

  assign current_grant_o = grant_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign err_zero_len_o  = err_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Testbench: tb_noc_packet_injector
// Purpose: Directed scenarios for reset, a single packet, round-robin order,
//   back-to-back packets, zero-length descriptors and reset mid-packet, plus a
//   randomized run with random backpressure checked every cycle against a
//   packet-level reference model (round-robin pointer, flit queue per packet).
module tb_noc_packet_injector;

  localparam int N  = 4;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XW-1:0]   srcX, srcY;
  logic [N-1:0]    reqValid, reqReady;
  logic [N*XW-1:0] reqX;
  logic [N*YW-1:0] reqY;
  logic [N*8-1:0]  reqLen;
  logic [N-1:0]    dataTvalid, dataTready;
  logic [N*DW-1:0] dataTdata;
  logic            outTvalid, outTready;
  logic [DW-1:0]   outTdata;
  logic [1:0]      currentGrant;
  logic            busy, errZeroLen;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  noc_packet_injector dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_x_i          (srcX),
    .src_y_i          (srcY),
    .req_valid_i      (reqValid),
    .req_ready_o      (reqReady),
    .req_x_i          (reqX),
    .req_y_i          (reqY),
    .req_len_i        (reqLen),
    .data_in_tvalid_i (dataTvalid),
    .data_in_tready_o (dataTready),
    .data_in_tdata_i  (dataTdata),
    .out_tvalid_o     (outTvalid),
    .out_tready_i     (outTready),
    .out_tdata_o      (outTdata),
    .current_grant_o  (currentGrant),
    .busy_o           (busy),
    .err_zero_len_o   (errZeroLen)
  );

  // Expected routing header: type 2'b10 on top, len at [15:8], src x [7:6],
  // src y [5:4], target x [3:2], target y [1:0].
  function automatic logic [31:0] hdrModel(input int len, input int sx, input int sy,
                                           input int tx, input int ty);
    return 32'h8000_0000 + 32'(len * 256) + 32'(sx * 64) + 32'(sy * 16) + 32'(tx * 4) + 32'(ty);
  endfunction

  task automatic setDesc(input int r, input int x, input int y, input int len);
    reqX[r*XW +: XW] = 2'(x);
    reqY[r*YW +: YW] = 2'(y);
    reqLen[r*8 +: 8] = 8'(len);
  endtask

  task automatic setData(input int r, input logic v, input logic [31:0] d);
    dataTvalid[r]        = v;
    dataTdata[r*DW +: DW] = d;
  endtask

  task automatic clearInputs();
    reqValid = '0; reqX = '0; reqY = '0; reqLen = '0;
    dataTvalid = '0; dataTdata = '0; outTready = 1'b0;
    srcX = '0; srcY = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    testsRun++; if (outTvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_tvalid: got %b want 0", outTvalid); end
    testsRun++; if (reqReady !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_req_ready: got %b want 0000", reqReady); end
    testsRun++; if (dataTready !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_tready: got %b want 0000", dataTready); end
    testsRun++; if (currentGrant !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_grant: got %0d want 0", currentGrant); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testsRun++; if (errZeroLen !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b want 0", errZeroLen); end
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [31:0] beat;
    doReset();
    setDesc(0, 2, 1, 3);
    reqValid = 4'b0001;
    outTready = 1'b1;
    setData(0, 1'b1, 32'h1111_0000);
    @(negedge clk);
    testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_ready: got %b want 0001", reqReady); end
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    testsRun++; if (outTvalid !== 1'b1 || outTdata !== hdrModel(3, 0, 0, 2, 1)) begin
      testsFailed++; $display("[TB] FAIL single_header: got v=%b %h want v=1 %h", outTvalid, outTdata, hdrModel(3, 0, 0, 2, 1));
    end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      beat = 32'h1111_0000 + 32'(k);
      setData(0, 1'b1, beat);
      @(negedge clk);
      testsRun++; if (outTvalid !== 1'b1 || outTdata !== beat || dataTready !== 4'b0001) begin
        testsFailed++; $display("[TB] FAIL single_beat%0d: got v=%b %h tready=%b want v=1 %h tready=0001", k, outTvalid, outTdata, dataTready, beat);
      end
    end
    nextCycle();
    setData(0, 1'b0, '0);
    @(negedge clk);
    testsRun++; if (busy !== 1'b0 || outTvalid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL single_done: got busy=%b v=%b want 0 0", busy, outTvalid);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int expOrder[4] = '{1, 3, 0, 1};
    doReset();
    for (int r = 0; r < N; r++) begin
      setDesc(r, 1, 1, 1);
      setData(r, 1'b1, 32'(r));
    end
    reqValid = 4'b1011;
    outTready = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) if (reqReady[r]) order.push_back(r);
      testsRun++; if ((dataTready & ~(4'b0001 << currentGrant)) !== 4'b0) begin
        testsFailed++; $display("[TB] FAIL rr_interleave: got tready=%b grant=%0d want only granted", dataTready, currentGrant);
      end
      nextCycle();
    end
    reqValid = '0;
    testsRun++; if (order.size() != 4) begin testsFailed++; $display("[TB] FAIL rr_timeout: got %0d grants want 4", order.size()); end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      testsRun++; if (order[i] != expOrder[i]) begin testsFailed++; $display("[TB] FAIL rr_order%0d: got %0d want %0d", i, order[i], expOrder[i]); end
    end
    repeat (4) nextCycle();
  endtask

  task automatic test_back_to_back();
    doReset();
    srcX = 2'd1; srcY = 2'd2;
    setDesc(1, 3, 0, 1);
    reqValid = 4'b0010;
    outTready = 1'b1;
    setData(1, 1'b1, 32'h0AAA_0001);
    setData(2, 1'b1, 32'h0BBB_0002);
    @(negedge clk);
    testsRun++; if (reqReady !== 4'b0010) begin testsFailed++; $display("[TB] FAIL b2b_ready1: got %b want 0010", reqReady); end
    nextCycle();
    reqValid = 4'b0100;
    setDesc(2, 0, 2, 2);
    @(negedge clk);
    testsRun++; if (reqReady !== 4'b0000 || outTdata !== hdrModel(1, 1, 2, 3, 0)) begin
      testsFailed++; $display("[TB] FAIL b2b_header1: got ready=%b %h want 0000 %h", reqReady, outTdata, hdrModel(1, 1, 2, 3, 0));
    end
    nextCycle();
    @(negedge clk);
    testsRun++; if (outTvalid !== 1'b1 || outTdata !== 32'h0AAA_0001 || reqReady !== 4'b0100) begin
      testsFailed++; $display("[TB] FAIL b2b_last_beat: got v=%b %h ready=%b want 1 0aaa0001 0100", outTvalid, outTdata, reqReady);
    end
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    testsRun++; if (outTvalid !== 1'b1 || outTdata !== hdrModel(2, 1, 2, 0, 2) || currentGrant !== 2'd2) begin
      testsFailed++; $display("[TB] FAIL b2b_header2: got v=%b %h g=%0d want 1 %h 2", outTvalid, outTdata, currentGrant, hdrModel(2, 1, 2, 0, 2));
    end
    repeat (4) nextCycle();
    @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_done: got busy=%b want 0", busy); end
  endtask

  task automatic test_zero_len();
    doReset();
    srcX = 2'd3; srcY = 2'd3;
    setDesc(1, 1, 1, 0);
    setDesc(3, 2, 3, 2);
    reqValid = 4'b1010;
    outTready = 1'b1;
    setData(3, 1'b1, 32'h0CCC_0003);
    @(negedge clk);
    testsRun++; if (reqReady !== 4'b0010 || errZeroLen !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL zl_accept: got ready=%b err=%b want 0010 0", reqReady, errZeroLen);
    end
    nextCycle();
    reqValid = 4'b1000;
    @(negedge clk);
    testsRun++; if (errZeroLen !== 1'b1 || outTvalid !== 1'b0 || busy !== 1'b0 || reqReady !== 4'b1000) begin
      testsFailed++; $display("[TB] FAIL zl_pulse: got err=%b v=%b busy=%b ready=%b want 1 0 0 1000", errZeroLen, outTvalid, busy, reqReady);
    end
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    testsRun++; if (errZeroLen !== 1'b0 || outTvalid !== 1'b1 || outTdata !== hdrModel(2, 3, 3, 2, 3) || currentGrant !== 2'd3) begin
      testsFailed++; $display("[TB] FAIL zl_next: got err=%b v=%b %h g=%0d want 0 1 %h 3", errZeroLen, outTvalid, outTdata, currentGrant, hdrModel(2, 3, 3, 2, 3));
    end
    repeat (4) nextCycle();
  endtask

  task automatic test_reset_mid_packet();
    doReset();
    setDesc(2, 1, 3, 5);
    reqValid = 4'b0100;
    outTready = 1'b1;
    setData(2, 1'b1, 32'h0DDD_0004);
    nextCycle();
    reqValid = '0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    testsRun++; if (busy !== 1'b1 || outTvalid !== 1'b1 || outTdata !== 32'h0DDD_0004) begin
      testsFailed++; $display("[TB] FAIL rstmid_beat2: got busy=%b v=%b %h want 1 1 0ddd0004", busy, outTvalid, outTdata);
    end
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    setData(2, 1'b0, '0);
    @(negedge clk);
    testsRun++; if (outTvalid !== 1'b0 || currentGrant !== 2'd0 || busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rstmid_abort: got v=%b g=%0d busy=%b want 0 0 0", outTvalid, currentGrant, busy);
    end
    nextCycle();
    setDesc(0, 3, 2, 2);
    reqValid = 4'b0001;
    setData(0, 1'b1, 32'h0EEE_0005);
    @(negedge clk);
    testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL rstmid_ready: got %b want 0001", reqReady); end
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    testsRun++; if (outTdata !== hdrModel(2, 0, 0, 3, 2)) begin
      testsFailed++; $display("[TB] FAIL rstmid_header: got %h want %h", outTdata, hdrModel(2, 0, 0, 3, 2));
    end
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      @(negedge clk);
      testsRun++; if (outTvalid !== 1'b1 || dataTready !== 4'b0001) begin
        testsFailed++; $display("[TB] FAIL rstmid_beat%0d: got v=%b tready=%b want 1 0001", k, outTvalid, dataTready);
      end
    end
    nextCycle();
    @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_done: got busy=%b want 0", busy); end
  endtask

  // Packet-level model: who wins, which flit is due next, how many payload
  // beats remain. Requesters hold descriptors and stream beats until taken.
  task automatic test_backpressure_random();
    bit dV[N]; int dX[N], dY[N], dL[N];
    bit sV[N]; logic [31:0] sD[N];
    bit mActive, mHdr, mErr; int mRem, mGrant, sx, sy, winner, rr;
    logic [31:0] mHdrVal, expData;
    logic expValid, hs, endPkt;
    logic [3:0] expReady, expTready;
    doReset();
    sx = int'($urandom_range(0, 3)); sy = int'($urandom_range(0, 3));
    srcX = 2'(sx); srcY = 2'(sy);
    mActive = 0; mHdr = 0; mErr = 0; mRem = 0; mGrant = 0; mHdrVal = '0;
    for (int r = 0; r < N; r++) begin dV[r] = 0; sV[r] = 0; sD[r] = '0; dX[r] = 0; dY[r] = 0; dL[r] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!dV[r] && $urandom_range(0, 3) == 0) begin
          dV[r] = 1; dX[r] = int'($urandom_range(0, 3)); dY[r] = int'($urandom_range(0, 3));
          dL[r] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 5));
        end
        if (!sV[r] && $urandom_range(0, 2) != 0) begin sV[r] = 1; sD[r] = {1'b0, 31'($urandom)}; end
        reqValid[r] = dV[r];
        setDesc(r, dX[r], dY[r], dL[r]);
        setData(r, sV[r], sD[r]);
      end
      outTready = 1'($urandom_range(0, 1));
      @(negedge clk);
      expData = '0;
      if (!mActive) expValid = 1'b0;
      else if (mHdr) begin expValid = 1'b1; expData = mHdrVal; end
      else begin expValid = sV[mGrant]; expData = sD[mGrant]; end
      hs = expValid && outTready;
      endPkt = mActive && !mHdr && hs && (mRem == 1);
      winner = -1;
      if (!mActive || endPkt) begin
        for (int k = 1; k <= N; k++) begin
          rr = (mGrant + k) % N;
          if (winner < 0 && dV[rr]) winner = rr;
        end
      end
      expReady  = (winner >= 0) ? 4'(1 << winner) : 4'b0;
      expTready = (mActive && !mHdr) ? (4'(outTready) << mGrant) : 4'b0;
      testsRun++; if (outTvalid !== expValid) begin testsFailed++; $display("[TB] FAIL rnd_tvalid c%0d: got %b want %b", cyc, outTvalid, expValid); end
      if (expValid) begin
        testsRun++; if (outTdata !== expData) begin testsFailed++; $display("[TB] FAIL rnd_tdata c%0d: got %h want %h", cyc, outTdata, expData); end
      end
      testsRun++; if (reqReady !== expReady) begin testsFailed++; $display("[TB] FAIL rnd_req_ready c%0d: got %b want %b", cyc, reqReady, expReady); end
      testsRun++; if (dataTready !== expTready) begin testsFailed++; $display("[TB] FAIL rnd_in_tready c%0d: got %b want %b", cyc, dataTready, expTready); end
      testsRun++; if (currentGrant !== 2'(mGrant) || busy !== mActive) begin
        testsFailed++; $display("[TB] FAIL rnd_grant_busy c%0d: got g=%0d b=%b want g=%0d b=%b", cyc, currentGrant, busy, mGrant, mActive);
      end
      testsRun++; if (errZeroLen !== mErr) begin testsFailed++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", cyc, errZeroLen, mErr); end
      mErr = 0;
      if (hs) begin
        if (mHdr) mHdr = 0;
        else begin
          mRem--;
          sV[mGrant] = 0;
          if (mRem == 0) mActive = 0;
        end
      end
      if (winner >= 0) begin
        mGrant = winner;
        dV[winner] = 0;
        if (dL[winner] == 0) mErr = 1;
        else begin
          mActive = 1; mHdr = 1; mRem = dL[winner];
          mHdrVal = hdrModel(dL[winner], sx, sy, dX[winner], dY[winner]);
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_zero_len();
    test_reset_mid_packet();
    test_backpressure_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
